// File: rtl/tone_square_gen.sv
// tone_square_gen
//   Square-wave buzzer driver. The frequency word is a half-period length in
//   clock cycles; the buzzer toggles each time a half-period completes.
//   A new frequency word is picked up only at half-period boundaries, so the
//   output never glitches. Stopping never cuts a high half-period short.
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   enable       1 = tone requested
//   frequency    half-period in clk cycles; values below MIN_DIV mean mute
//   buzzer       registered square-wave output
//   tone_active  high whenever the FSM is not idle
//   period_tick  one-cycle pulse coincident with each rising edge of buzzer
module tone_square_gen #(
  parameter int DIV_W   = 15,
  parameter int MIN_DIV = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [DIV_W-1:0] frequency,
  output logic             buzzer,
  output logic             tone_active,
  output logic             period_tick
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [DIV_W-1:0] MIN_DIV_W = DIV_W'(MIN_DIV);
  localparam logic [DIV_W-1:0] ONE_W     = DIV_W'(1);
  localparam logic [DIV_W-1:0] ZERO_W    = '0;

  state_t           state_r;
  state_t           state_s;
  logic [DIV_W-1:0] cnt_r;
  logic [DIV_W-1:0] cnt_s;
  logic [DIV_W-1:0] div_r;
  logic [DIV_W-1:0] div_s;
  logic             buzzer_s;
  logic             tick_s;
  logic             freq_ok_s;
  logic             start_ok_s;
  logic             wrap_s;

  // Frequency legality, start condition and half-period completion.
  // div_r is at least MIN_DIV outside IDLE, so div_r - 1 cannot underflow
  // where wrap_s is used.
  assign freq_ok_s   = (frequency >= MIN_DIV_W);
  assign start_ok_s  = enable && freq_ok_s;
  assign wrap_s      = (cnt_r == (div_r - ONE_W));
  assign tone_active = (state_r != ST_IDLE);

  // Next-state, counter, latched divider and output computation.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    div_s    = div_r;
    buzzer_s = buzzer;
    tick_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        buzzer_s = 1'b0;
        cnt_s    = ZERO_W;
        if (start_ok_s) begin
          state_s  = ST_RUN;
          div_s    = frequency;
          buzzer_s = 1'b1;
          tick_s   = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!enable && !buzzer) begin
          // Low half: stop at once, no extra low time.
          state_s = ST_IDLE;
          cnt_s   = ZERO_W;
        end else if (!enable && wrap_s) begin
          // High half just completed: no need to drain another half.
          state_s  = ST_IDLE;
          buzzer_s = 1'b0;
          cnt_s    = ZERO_W;
        end else if (!enable) begin
          // High half still in progress: finish it in DRAIN.
          state_s = ST_DRAIN;
          cnt_s   = cnt_r + ONE_W;
        end else if (!wrap_s) begin
          cnt_s = cnt_r + ONE_W;
        end else begin
          cnt_s = ZERO_W;
          if (freq_ok_s) begin
            div_s    = frequency;
            buzzer_s = ~buzzer;
            tick_s   = ~buzzer;
          end else begin
            buzzer_s = 1'b0;
            state_s  = ST_IDLE;
          end
        end
      end
      ST_DRAIN: begin
        if (wrap_s) begin
          buzzer_s = 1'b0;
          cnt_s    = ZERO_W;
          state_s  = ST_IDLE;
        end else begin
          cnt_s = cnt_r + ONE_W;
        end
      end
      default: begin
        state_s  = ST_IDLE;
        cnt_s    = ZERO_W;
        div_s    = ZERO_W;
        buzzer_s = 1'b0;
      end
    endcase
  end

  // State, counter, divider and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= ZERO_W;
      div_r       <= ZERO_W;
      buzzer      <= 1'b0;
      period_tick <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      div_r       <= div_s;
      buzzer      <= buzzer_s;
      period_tick <= tick_s;
    end
  end

endmodule
